// File: rtl/alu_step_sequencer_pkg.sv
// Shared types and constants for the ALU control-step sequencer.
// States, IR field layout, datapath strobe bundle and defaults.
package alu_seq_pkg;

  localparam int IR_W = 32;
  localparam int IR_MSB = IR_W - 1;

  localparam int OPC_W_DEF = 5;
  localparam int NREG_DEF = 16;
  localparam int INCPC_OP_DEF = 12;
  localparam int MEM_WAIT_MAX_DEF = 15;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0 = 3'd1;
  localparam logic [2:0] S_T1 = 3'd2;
  localparam logic [2:0] S_T2 = 3'd3;
  localparam logic [2:0] S_T3 = 3'd4;
  localparam logic [2:0] S_T4 = 3'd5;
  localparam logic [2:0] S_T5 = 3'd6;
  localparam logic [2:0] S_HALT = 3'd7;

  typedef struct packed {
    logic PCout;
    logic MARin;
    logic Zin;
    logic Zlowout;
    logic PCin;
    logic Read;
    logic MDRin;
    logic MDRout;
    logic IRin;
    logic Yin;
  } ctrl_t;

endpackage

// File: rtl/alu_step_sequencer_if.sv
// Sequencer <-> datapath bundle: run/IR/memory status in,
// control strobes and status out.
interface alu_step_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int OPC_W = OPC_W_DEF,
  parameter int NREG = NREG_DEF
);
  logic run;
  logic [IR_W-1:0] ir;
  logic mem_done;

  logic PCout, MARin, Zin, Zlowout, PCin;
  logic Read, MDRin, MDRout, IRin, Yin;
  logic [NREG-1:0] Rout;
  logic [NREG-1:0] Rin;
  logic [OPC_W-1:0] alu_op;
  logic busy, instr_done, illegal, timeout;

  modport master (
    input run, ir, mem_done,
    output PCout, MARin, Zin, Zlowout, PCin,
    output Read, MDRin, MDRout, IRin, Yin,
    output Rout, Rin, alu_op,
    output busy, instr_done, illegal, timeout
  );

  modport slave (
    output run, ir, mem_done,
    input PCout, MARin, Zin, Zlowout, PCin,
    input Read, MDRin, MDRout, IRin, Yin,
    input Rout, Rin, alu_op,
    input busy, instr_done, illegal, timeout
  );
endinterface

// File: rtl/alu_step_sequencer_reg_sel_decoder.sv
// Register select field to one-hot enable vector,
// all-zero when not enabled.
module reg_sel_decoder #(
  parameter int NREG = 16,
  parameter int SEL_W = $clog2(NREG)
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [NREG-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/alu_step_sequencer.sv
// Moore FSM issuing T0..T5 datapath strobes for fetch and
// register-register ALU execute, with memory wait and halt.
module alu_step_sequencer
  import alu_seq_pkg::*;
#(
  parameter int OPC_W = OPC_W_DEF,
  parameter int NREG = NREG_DEF,
  parameter int INCPC_OP = INCPC_OP_DEF,
  parameter logic [(1<<OPC_W)-1:0] ALU_OP_MASK = '1,
  parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF
) (
  input logic clk,
  input logic clr,
  alu_step_sequencer_if.master bus
);

  localparam int SEL_W = $clog2(NREG);
  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam int OPC_LSB = IR_MSB + 1 - OPC_W;
  localparam int RA_LSB = OPC_LSB - SEL_W;
  localparam int RB_LSB = RA_LSB - SEL_W;
  localparam int RC_LSB = RB_LSB - SEL_W;
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_WAIT_MAX);
  localparam logic [OPC_W-1:0] INC_OP = OPC_W'(INCPC_OP);

  logic [2:0] state_q, state_d;
  logic first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic [OPC_W-1:0] opcode;
  logic [SEL_W-1:0] ra, rb, rc;
  logic legal;
  logic ir_unused;

  assign opcode = bus.ir[IR_MSB -: OPC_W];
  assign ra = bus.ir[RA_LSB +: SEL_W];
  assign rb = bus.ir[RB_LSB +: SEL_W];
  assign rc = bus.ir[RC_LSB +: SEL_W];
  assign legal = ALU_OP_MASK[opcode];
  assign ir_unused = ^bus.ir[RC_LSB-1:0];
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    first_d = 1'b0;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: if (bus.run) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        first_d = 1'b1;
        cnt_d = '0;
      end
      S_T1: begin
        if (bus.mem_done) begin
          state_d = S_T2;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == WAIT_MAX) state_d = S_HALT;
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (legal) state_d = S_T4;
        else state_d = bus.run ? S_T0 : S_IDLE;
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = bus.run ? S_T0 : S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      cnt_q <= cnt_d;
    end
  end

  ctrl_t ctrl;
  logic rout_en, rin_en;
  logic [SEL_W-1:0] rout_sel;
  logic [OPC_W-1:0] alu_op;
  logic illegal, instr_done;
  logic [NREG-1:0] rout_oh, rin_oh;

  always_comb begin
    ctrl = '0;
    rout_en = 1'b0;
    rout_sel = rb;
    rin_en = 1'b0;
    alu_op = '0;
    illegal = 1'b0;
    instr_done = 1'b0;
    unique case (1'b1)
      (state_q == S_T0): begin
        ctrl.PCout = 1'b1;
        ctrl.MARin = 1'b1;
        ctrl.Zin = 1'b1;
        alu_op = INC_OP;
      end
      // PC load only on the first T1 cycle so waits don't re-increment
      (state_q == S_T1): begin
        ctrl.Zlowout = first_q;
        ctrl.PCin = first_q;
        ctrl.Read = 1'b1;
        ctrl.MDRin = 1'b1;
      end
      (state_q == S_T2): begin
        ctrl.MDRout = 1'b1;
        ctrl.IRin = 1'b1;
      end
      (state_q == S_T3): begin
        ctrl.Yin = legal;
        rout_en = legal;
        illegal = !legal;
      end
      (state_q == S_T4): begin
        ctrl.Zin = 1'b1;
        rout_en = 1'b1;
        rout_sel = rc;
        alu_op = opcode;
      end
      (state_q == S_T5): begin
        ctrl.Zlowout = 1'b1;
        rin_en = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  reg_sel_decoder #(.NREG(NREG), .SEL_W(SEL_W)) u_rout_dec (
    .en(rout_en),
    .sel(rout_sel),
    .onehot(rout_oh)
  );

  reg_sel_decoder #(.NREG(NREG), .SEL_W(SEL_W)) u_rin_dec (
    .en(rin_en),
    .sel(ra),
    .onehot(rin_oh)
  );

  assign bus.PCout = ctrl.PCout;
  assign bus.MARin = ctrl.MARin;
  assign bus.Zin = ctrl.Zin;
  assign bus.Zlowout = ctrl.Zlowout;
  assign bus.PCin = ctrl.PCin;
  assign bus.Read = ctrl.Read;
  assign bus.MDRin = ctrl.MDRin;
  assign bus.MDRout = ctrl.MDRout;
  assign bus.IRin = ctrl.IRin;
  assign bus.Yin = ctrl.Yin;
  assign bus.Rout = rout_oh;
  assign bus.Rin = rin_oh;
  assign bus.alu_op = alu_op;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.instr_done = instr_done;
  assign bus.illegal = illegal;
  assign bus.timeout = (state_q == S_HALT);

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Bench for alu_step_sequencer: per-instruction expected strobe
// sequences built from the step rules, checked every cycle.
module tb_alu_step_sequencer;

  localparam logic [31:0] MASK = 32'h0000_3FE0;

  localparam logic [9:0] PCOUT = 10'h200;
  localparam logic [9:0] MARIN = 10'h100;
  localparam logic [9:0] ZIN = 10'h080;
  localparam logic [9:0] ZLOW = 10'h040;
  localparam logic [9:0] PCIN = 10'h020;
  localparam logic [9:0] READ = 10'h010;
  localparam logic [9:0] MDRIN = 10'h008;
  localparam logic [9:0] MDROUT = 10'h004;
  localparam logic [9:0] IRIN = 10'h002;
  localparam logic [9:0] YIN = 10'h001;

  logic clk = 1'b0;
  logic clr;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_step_sequencer_if #(.OPC_W(5), .NREG(16)) bus ();

  alu_step_sequencer #(.ALU_OP_MASK(MASK)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  function automatic bit rb1();
    return 1'($urandom);
  endfunction

  function automatic logic [63:0] mk(
    input logic [9:0] s, input int ro, input int ri,
    input int op, input bit bz, input bit dn,
    input bit il, input bit to);
    logic [15:0] rov;
    logic [15:0] riv;
    logic [4:0] opv;
    rov = '0;
    riv = '0;
    if (ro >= 0) rov[ro] = 1'b1;
    if (ri >= 0) riv[ri] = 1'b1;
    opv = 5'(op);
    return {13'd0, s, rov, riv, opv, bz, dn, il, to};
  endfunction

  function automatic logic [63:0] obs();
    return {13'd0, bus.PCout, bus.MARin, bus.Zin, bus.Zlowout,
            bus.PCin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin,
            bus.Yin, bus.Rout, bus.Rin, bus.alu_op, bus.busy,
            bus.instr_done, bus.illegal, bus.timeout};
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [63:0] exp,
                      input bit r, input bit md);
    @(posedge clk);
    #1;
    check(tag, obs(), exp);
    bus.run = r;
    bus.mem_done = md;
  endtask

  task automatic do_clr();
    #2 clr = 1'b1;
    #1 check("clr", obs(), 64'd0);
    bus.run = 1'b0;
    bus.mem_done = 1'b0;
    #2 clr = 1'b0;
    step("idle_after_clr", 64'd0, 1'b0, 1'b0);
    step("idle", 64'd0, 1'b1, rb1());
  endtask

  task automatic idle_then_run();
    repeat (2) step("idle", 64'd0, 1'b0, rb1());
    step("idle", 64'd0, 1'b1, rb1());
  endtask

  // kind: 0 = normal, 1 = memory never answers, 2 = clr during wait
  task automatic instr(input int op, input int ra, input int rb,
                       input int rc, input int w, input int kind,
                       input bit run_after);
    bit legal;
    int nw;
    string t;
    legal = MASK[op];
    nw = (kind == 1) ? 15 : ((kind == 2) ? 4 : w + 1);
    step("T0", mk(PCOUT | MARIN | ZIN, -1, -1, 12, 1, 0, 0, 0),
         rb1(), rb1());
    bus.ir = {op[4:0], ra[3:0], rb[3:0], rc[3:0], 15'd0};
    for (int j = 0; j < nw; j++) begin
      if (j == 0) begin
        t = "T1";
        step(t, mk(ZLOW | PCIN | READ | MDRIN, -1, -1, 0, 1, 0, 0, 0),
             rb1(), (kind == 0) && (j == w));
      end else begin
        t = "T1wait";
        step(t, mk(READ | MDRIN, -1, -1, 0, 1, 0, 0, 0),
             rb1(), (kind == 0) && (j == w));
      end
    end
    if (kind == 1) begin
      repeat (4) step("halt", mk(10'd0, -1, -1, 0, 1, 0, 0, 1),
                      rb1(), rb1());
      do_clr();
      return;
    end
    if (kind == 2) begin
      do_clr();
      return;
    end
    step("T2", mk(MDROUT | IRIN, -1, -1, 0, 1, 0, 0, 0), rb1(), rb1());
    if (!legal) begin
      step("T3ill", mk(10'd0, -1, -1, 0, 1, 0, 1, 0), run_after, rb1());
    end else begin
      step("T3", mk(YIN, rb, -1, 0, 1, 0, 0, 0),
           run_after ? rb1() : 1'b0, rb1());
      step("T4", mk(ZIN, rc, -1, op, 1, 0, 0, 0), rb1(), rb1());
      step("T5", mk(ZLOW, -1, ra, 0, 1, 1, 0, 0), run_after, rb1());
    end
    if (!run_after) idle_then_run();
  endtask

  initial begin
    clr = 1'b1;
    bus.run = 1'b0;
    bus.mem_done = 1'b0;
    bus.ir = '0;
    #8 check("reset", obs(), 64'd0);
    #4 clr = 1'b0;
    step("idle", 64'd0, 1'b0, 1'b0);
    step("idle", 64'd0, 1'b1, 1'b0);

    instr(5, 1, 2, 3, 0, 0, 1'b1);
    instr(5, 1, 2, 3, 3, 0, 1'b1);
    instr(31, 0, 1, 2, 0, 0, 1'b1);
    instr(8, 6, 6, 4, 1, 0, 1'b0);
    instr(9, 3, 7, 3, 2, 2, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 31);
      if (rb1()) op = $urandom_range(5, 13);
      instr(op, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 4), 0, rb1());
    end

    instr(12, 15, 0, 15, 0, 1, 1'b1);
    instr(6, 15, 15, 15, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
